// File: rtl/conv_ctrl_block.sv
// conv_ctrl_block
//   Command decoder and run-control sequencer sitting between a GPIO command
//   port and a 2D-convolution datapath. A rising edge on i_GPIOvalid accepts
//   one command (opcode i_GPIOctrl, payload i_GPIOdata). Kernel words are
//   addressed into the conv unit, image words are pulsed to the FSM, and the
//   IDLE -> RUN -> DONE handshake is sequenced. Results (or an optional status
//   word) are returned on o_GPIOdata.
//
//   Optional feature macro: CONV_CTRL_STATUS_EN (opcode 7 returns a status
//   word; when undefined, opcode 7 is illegal and sets err).
//
// Ports
//   i_CLK, i_rst            clock, async active-low reset
//   i_GPIOctrl/valid/data   command opcode, strobe, payload
//   i_EOP_from_FSM          end-of-processing level from the datapath FSM
//   i_MCUdata               result pixel, sampled on a data-request command
//   o_GPIOdata              readback word
//   o_KNLdata/o_KNLaddr     kernel word and its index
//   o_valid_to_CONV/FSM     one-cycle kernel / image word pulses
//   o_KNorIMG               0 = kernel mode, 1 = image mode
//   o_imgLength             image length
//   o_MCUreq                one-cycle data-request pulse
//   o_SoP / o_EOP_to_MCU    high in RUN / high in DONE
//   o_led                   {err, EOP, SoP}
module conv_ctrl_block #(
  parameter  int GPIO_DW   = 24,
  parameter  int PIX_W     = 13,
  parameter  int LEN_W     = 10,
  parameter  int KNL_WORDS = 3,
  localparam int KA_W      = $clog2(KNL_WORDS)
) (
  input  logic               i_CLK,
  input  logic               i_rst,
  input  logic [2:0]         i_GPIOctrl,
  input  logic               i_GPIOvalid,
  input  logic [GPIO_DW-1:0] i_GPIOdata,
  input  logic               i_EOP_from_FSM,
  input  logic [PIX_W-1:0]   i_MCUdata,
  output logic [31:0]        o_GPIOdata,
  output logic [GPIO_DW-1:0] o_KNLdata,
  output logic [KA_W-1:0]    o_KNLaddr,
  output logic               o_valid_to_CONV,
  output logic               o_valid_to_FSM,
  output logic               o_KNorIMG,
  output logic [LEN_W-1:0]   o_imgLength,
  output logic               o_MCUreq,
  output logic               o_SoP,
  output logic               o_EOP_to_MCU,
  output logic [2:0]         o_led
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic               vprev_q;
  logic [KA_W-1:0]    knl_cnt_q, knl_cnt_d;
  logic               knl_full_q, knl_full_d;
  logic [15:0]        img_cnt_q, img_cnt_d;
  logic               err_q, err_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [GPIO_DW-1:0] knl_data_q, knl_data_d;
  logic [KA_W-1:0]    knl_addr_q, knl_addr_d;
  logic               kimg_q, kimg_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [31:0]        gpio_q, gpio_d;
  logic               conv_q, conv_d;
  logic               fsm_q, fsm_d;
  logic               req_q, req_d;

  logic               acc;
  logic               abort;
  logic [31:0]        mcu_ext;

  assign acc   = i_GPIOvalid & ~vprev_q;
  assign abort = acc & (i_GPIOctrl == 3'd6);

  always_comb begin
    state_d    = state_q;
    knl_cnt_d  = knl_cnt_q;
    knl_full_d = knl_full_q;
    img_cnt_d  = img_cnt_q;
    err_d      = err_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    knl_data_d = knl_data_q;
    knl_addr_d = knl_addr_q;
    kimg_d     = kimg_q;
    len_d      = len_q;
    gpio_d     = gpio_q;
    conv_d     = 1'b0;
    fsm_d      = 1'b0;
    req_d      = 1'b0;
    mcu_ext    = '0;
    mcu_ext[PIX_W-1:0] = i_MCUdata;

    // EOP is only honoured in RUN and loses to a same-cycle abort.
    if (state_q == S_RUN && i_EOP_from_FSM && !abort) begin
      state_d = S_DONE;
      sop_d   = 1'b0;
      eop_d   = 1'b1;
    end

    if (abort) begin
      state_d    = S_IDLE;
      knl_cnt_d  = '0;
      knl_full_d = 1'b0;
      img_cnt_d  = '0;
      err_d      = 1'b0;
      sop_d      = 1'b0;
      eop_d      = 1'b0;
    end else if (acc && i_GPIOctrl == 3'd7) begin
`ifdef CONV_CTRL_STATUS_EN
      gpio_d = {state_q, err_q, knl_full_q, 4'b0, 8'(knl_cnt_q), img_cnt_q};
`else
      err_d = 1'b1;
`endif
    end else if (acc) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (i_GPIOctrl)
            3'd0: begin
              knl_data_d = i_GPIOdata;
              knl_addr_d = knl_cnt_q;
              conv_d     = 1'b1;
              kimg_d     = 1'b0;
              if (knl_cnt_q == KA_W'(KNL_WORDS - 1)) begin
                knl_cnt_d  = '0;
                knl_full_d = 1'b1;
              end else begin
                knl_cnt_d = knl_cnt_q + 1'b1;
              end
            end
            3'd1: begin
              len_d     = i_GPIOdata[LEN_W-1:0];
              img_cnt_d = '0;
              kimg_d    = 1'b1;
            end
            3'd2: begin
              fsm_d     = 1'b1;
              kimg_d    = 1'b1;
              img_cnt_d = img_cnt_q + 16'd1;
            end
            3'd3: begin
              gpio_d = mcu_ext;
              req_d  = 1'b1;
            end
            3'd4: begin
              if (knl_full_q) begin
                state_d = S_RUN;
                sop_d   = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            default: ; // ack is a no-op while configuring
          endcase
        end
        S_DONE: begin
          if (i_GPIOctrl == 3'd3) begin
            gpio_d = mcu_ext;
            req_d  = 1'b1;
          end else if (i_GPIOctrl == 3'd5) begin
            // knl_full survives the ack so a restart needs no kernel reload
            state_d = S_IDLE;
            eop_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1; // RUN accepts nothing but abort
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      vprev_q    <= 1'b1; // a strobe held through reset release is not a command
      knl_cnt_q  <= '0;
      knl_full_q <= 1'b0;
      img_cnt_q  <= '0;
      err_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      knl_data_q <= '0;
      knl_addr_q <= '0;
      kimg_q     <= 1'b1;
      len_q      <= '0;
      gpio_q     <= '0;
      conv_q     <= 1'b0;
      fsm_q      <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vprev_q    <= i_GPIOvalid;
      knl_cnt_q  <= knl_cnt_d;
      knl_full_q <= knl_full_d;
      img_cnt_q  <= img_cnt_d;
      err_q      <= err_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      knl_data_q <= knl_data_d;
      knl_addr_q <= knl_addr_d;
      kimg_q     <= kimg_d;
      len_q      <= len_d;
      gpio_q     <= gpio_d;
      conv_q     <= conv_d;
      fsm_q      <= fsm_d;
      req_q      <= req_d;
    end
  end

  assign o_GPIOdata      = gpio_q;
  assign o_KNLdata       = knl_data_q;
  assign o_KNLaddr       = knl_addr_q;
  assign o_valid_to_CONV = conv_q;
  assign o_valid_to_FSM  = fsm_q;
  assign o_KNorIMG       = kimg_q;
  assign o_imgLength     = len_q;
  assign o_MCUreq        = req_q;
  assign o_SoP           = sop_q;
  assign o_EOP_to_MCU    = eop_q;
  assign o_led           = {err_q, eop_q, sop_q};

endmodule

// File: tb/tb_conv_ctrl_block.sv
// Self-checking bench for conv_ctrl_block: directed scenarios followed by a
// randomized command stream, every cycle compared against a behavioural model.
module tb_conv_ctrl_block;
  localparam int KNL_WORDS = 3;

  logic        i_CLK = 1'b0;
  logic        i_rst;
  logic [2:0]  i_GPIOctrl;
  logic        i_GPIOvalid;
  logic [23:0] i_GPIOdata;
  logic        i_EOP_from_FSM;
  logic [12:0] i_MCUdata;
  logic [31:0] o_GPIOdata;
  logic [23:0] o_KNLdata;
  logic [1:0]  o_KNLaddr;
  logic        o_valid_to_CONV, o_valid_to_FSM, o_KNorIMG, o_MCUreq;
  logic [9:0]  o_imgLength;
  logic        o_SoP, o_EOP_to_MCU;
  logic [2:0]  o_led;

  conv_ctrl_block dut (
    .i_CLK(i_CLK), .i_rst(i_rst), .i_GPIOctrl(i_GPIOctrl), .i_GPIOvalid(i_GPIOvalid),
    .i_GPIOdata(i_GPIOdata), .i_EOP_from_FSM(i_EOP_from_FSM), .i_MCUdata(i_MCUdata),
    .o_GPIOdata(o_GPIOdata), .o_KNLdata(o_KNLdata), .o_KNLaddr(o_KNLaddr),
    .o_valid_to_CONV(o_valid_to_CONV), .o_valid_to_FSM(o_valid_to_FSM),
    .o_KNorIMG(o_KNorIMG), .o_imgLength(o_imgLength), .o_MCUreq(o_MCUreq),
    .o_SoP(o_SoP), .o_EOP_to_MCU(o_EOP_to_MCU), .o_led(o_led)
  );

  always #5 i_CLK = ~i_CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: state 0=IDLE 1=RUN 2=DONE; SoP/EOP follow from state.
  int          m_state, m_knl_cnt, m_img;
  bit          m_err, m_full, m_kimg, m_vprev;
  logic [23:0] m_kd;
  logic [1:0]  m_ka;
  logic [9:0]  m_len;
  logic [31:0] m_gpio;
  bit          p_conv, p_fsm, p_req;

  task automatic m_reset();
    m_state = 0; m_knl_cnt = 0; m_img = 0; m_err = 0; m_full = 0;
    m_kimg = 1; m_vprev = 1; m_kd = '0; m_ka = '0; m_len = '0; m_gpio = '0;
    p_conv = 0; p_fsm = 0; p_req = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".KNLdata"}, 32'(o_KNLdata), 32'(m_kd));
    chk({tag, ".KNLaddr"}, 32'(o_KNLaddr), 32'(m_ka));
    chk({tag, ".KNorIMG"}, 32'(o_KNorIMG), 32'(m_kimg));
    chk({tag, ".imgLength"}, 32'(o_imgLength), 32'(m_len));
    chk({tag, ".GPIOdata"}, o_GPIOdata, m_gpio);
    chk({tag, ".validCONV"}, 32'(o_valid_to_CONV), 32'(p_conv));
    chk({tag, ".validFSM"}, 32'(o_valid_to_FSM), 32'(p_fsm));
    chk({tag, ".MCUreq"}, 32'(o_MCUreq), 32'(p_req));
    chk({tag, ".SoP"}, 32'(o_SoP), 32'(m_state == 1));
    chk({tag, ".EOP"}, 32'(o_EOP_to_MCU), 32'(m_state == 2));
    chk({tag, ".led"}, 32'(o_led), {29'd0, m_err, m_state == 2, m_state == 1});
  endtask

  // One clock: drive inputs, advance the model by the spec's rules, check.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [23:0] d,
                       input logic [12:0] mcu, input logic eop, input string tag);
    bit acc;
    int s0;
    i_GPIOvalid = v; i_GPIOctrl = op; i_GPIOdata = d; i_MCUdata = mcu; i_EOP_from_FSM = eop;
    @(posedge i_CLK);
    acc = v && !m_vprev;
    m_vprev = v;
    p_conv = 0; p_fsm = 0; p_req = 0;
    s0 = m_state;
    if (s0 == 1 && eop && !(acc && op == 3'd6)) m_state = 2;
    if (acc) begin
      if (op == 3'd6) begin
        m_state = 0; m_knl_cnt = 0; m_full = 0; m_img = 0; m_err = 0;
      end else if (op == 3'd7) begin
`ifdef CONV_CTRL_STATUS_EN
        m_gpio = (32'(s0) << 30) | (32'(m_err) << 29) | (32'(m_full) << 28)
               | (32'(m_knl_cnt) << 16) | 32'(m_img);
`else
        m_err = 1;
`endif
      end else if (s0 == 0) begin
        case (op)
          3'd0: begin
            m_kd = d; m_ka = 2'(m_knl_cnt); p_conv = 1; m_kimg = 0;
            m_knl_cnt++;
            if (m_knl_cnt == KNL_WORDS) begin m_knl_cnt = 0; m_full = 1; end
          end
          3'd1: begin m_len = d[9:0]; m_img = 0; m_kimg = 1; end
          3'd2: begin p_fsm = 1; m_kimg = 1; m_img = (m_img + 1) % 65536; end
          3'd3: begin m_gpio = 32'(mcu); p_req = 1; end
          3'd4: if (m_full) m_state = 1; else m_err = 1;
          default: ;
        endcase
      end else if (s0 == 2 && op == 3'd3) begin
        m_gpio = 32'(mcu); p_req = 1;
      end else if (s0 == 2 && op == 3'd5) begin
        m_state = 0;
      end else begin
        m_err = 1;
      end
    end
    #1 chk_all(tag);
  endtask

  // Strobed command followed by a low cycle carrying junk opcode/payload.
  task automatic cmd(input logic [2:0] op, input logic [23:0] d, input logic [12:0] mcu,
                     input logic eop, input string tag);
    cycle(1'b1, op, d, mcu, eop, tag);
    cycle(1'b0, 3'($urandom), 24'($urandom), 13'($urandom), 1'b0, {tag, ".gap"});
  endtask

  initial begin
    i_rst = 1'b1; i_GPIOvalid = 1'b1; i_GPIOctrl = 3'd3; i_GPIOdata = '0;
    i_EOP_from_FSM = 1'b0; i_MCUdata = '0;
    #2 i_rst = 1'b0;
    m_reset();
    #1 chk_all("reset");
    repeat (2) @(posedge i_CLK);
    #1 i_rst = 1'b1;

    // strobe held high through reset release: no command
    repeat (5) cycle(1'b1, 3'd0, 24'hABCDEF, 13'h1FFF, 1'b0, "held");
    chk("held.led", 32'(o_led), 32'd0);
    chk("held.KNorIMG", 32'(o_KNorIMG), 32'd1);
    cycle(1'b0, 3'd0, '0, '0, 1'b0, "drop");

    // kernel load and start
    cmd(3'd0, 24'h010203, '0, 1'b0, "knl0");
    cmd(3'd0, 24'h040506, '0, 1'b0, "knl1");
    cmd(3'd0, 24'h070809, '0, 1'b0, "knl2");
    cmd(3'd4, '0, '0, 1'b0, "start");
    chk("start.SoP", 32'(o_SoP), 32'd1);

    // EOP, readback, ack
    cycle(1'b0, 3'd0, '0, '0, 1'b1, "eop");
    chk("eop.EOP", 32'(o_EOP_to_MCU), 32'd1);
    cycle(1'b0, 3'd0, '0, '0, 1'b0, "eop.low");
    cmd(3'd3, '0, 13'h1ABC, 1'b0, "rdbk");
    chk("rdbk.GPIOdata", o_GPIOdata, 32'h00001ABC);
    cmd(3'd5, '0, '0, 1'b0, "ack");

    // start without a full kernel
    cmd(3'd6, '0, '0, 1'b0, "abort0");
    cmd(3'd0, 24'h111111, '0, 1'b0, "pk0");
    cmd(3'd0, 24'h222222, '0, 1'b0, "pk1");
    cmd(3'd4, '0, '0, 1'b0, "badstart");
    chk("badstart.led", 32'(o_led), 32'b100);
    cmd(3'd6, '0, '0, 1'b0, "abort1");
    chk("abort1.led", 32'(o_led), 32'd0);

    // abort and EOP in the same RUN cycle
    for (int i = 0; i < 3; i++) cmd(3'd0, 24'($urandom), '0, 1'b0, "rk");
    cmd(3'd4, '0, '0, 1'b0, "start2");
    cmd(3'd6, '0, '0, 1'b1, "abort_eop");
    chk("abort_eop.EOP", 32'(o_EOP_to_MCU), 32'd0);

    // image size, image words, status
    cmd(3'd1, 24'h000200, '0, 1'b0, "isize");
    for (int i = 0; i < 4; i++) cmd(3'd2, 24'($urandom), '0, 1'b0, "iload");
    cmd(3'd7, '0, '0, 1'b0, "status");
    chk("status.imgLength", 32'(o_imgLength), 32'd512);
`ifdef CONV_CTRL_STATUS_EN
    chk("status.cnt", 32'(o_GPIOdata[15:0]), 32'd4);
    chk("status.state", 32'(o_GPIOdata[31:30]), 32'd0);
`else
    chk("status.err", 32'(o_led[2]), 32'd1);
`endif

    // reset mid-RUN
    cmd(3'd6, '0, '0, 1'b0, "abort2");
    for (int i = 0; i < 3; i++) cmd(3'd0, 24'($urandom), '0, 1'b0, "rk2");
    cmd(3'd4, '0, '0, 1'b0, "start3");
    @(negedge i_CLK);
    i_rst = 1'b0;
    m_reset();
    #1 chk_all("midrun_rst");
    @(posedge i_CLK);
    #1 i_rst = 1'b1;

    // randomized command stream
    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      op = 3'($urandom);
      if (op == 3'd6 && $urandom_range(0, 2) != 0) op = 3'd0; // keep aborts rarer
      if ($urandom_range(0, 3) == 0)
        cycle(1'b1, op, 24'($urandom), 13'($urandom), 1'($urandom), "rnd.hold");
      cmd(op, 24'($urandom), 13'($urandom), ($urandom_range(0, 3) == 0), "rnd");
      if ($urandom_range(0, 4) == 0)
        cycle(1'b0, 3'($urandom), 24'($urandom), 13'($urandom), 1'($urandom), "rnd.idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_ctrl_block.md
# conv_ctrl_block

Parametrised command decoder and run-control sequencer between the MicroBlaze GPIO port and the 2D-convolution datapath. It edge-detects GPIO command strobes and addresses kernel words into the convolution unit. It streams image words to the FSM, arbitrates the IDLE → RUN → DONE handshake, and returns pixel results or an optional status word to the processor.

## Interface
- GPIO_DW, 24, GPIO data payload width; must be ≤ 32.
- PIX_W, 13, MCU result pixel width; must be ≤ 32.
- LEN_W, 10, image length field width; must be ≤ 16.
- KNL_WORDS, 3, kernel words per kernel; range 2..256.
- KA_W, $clog2(KNL_WORDS), kernel address width (derived localparam).
- i_CLK  in  1  system clock; all flops rise-edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_GPIOctrl  in  3  opcode.
- i_GPIOvalid  in  1  command strobe; the rising edge qualifies a command.
- i_GPIOdata  in  GPIO_DW  command payload.
- i_EOP_from_FSM  in  1  end of processing, level.
- i_MCUdata  in  PIX_W  result pixel from MCU.
- o_GPIOdata  out  32  readback word.
- o_KNLdata  out  GPIO_DW  kernel word.
- o_KNLaddr  out  KA_W  kernel word index.
- o_valid_to_CONV  out  1  kernel write pulse.
- o_valid_to_FSM  out  1  image word pulse.
- o_KNorIMG  out  1  0 = kernel mode, 1 = image mode.
- o_imgLength  out  LEN_W  image length.
- o_MCUreq  out  1  data-request pulse.
- o_SoP  out  1  start of processing (high in RUN).
- o_EOP_to_MCU  out  1  end of processing (high in DONE).
- o_led  out  3  {err, EOP, SoP}.

## Operation

**States.** IDLE (config), RUN, DONE; 2-bit encoding 0/1/2.

**Command acceptance.**
- A command is accepted at a clock edge where i_GPIOvalid=1 and vprev=0.
- vprev is a register of i_GPIOvalid.

**Opcodes in IDLE.**
- 0 Kernel load:
  - o_KNLdata←data; o_KNLaddr←knl_cnt.
  - o_valid_to_CONV pulse; o_KNorIMG←0.
  - knl_cnt increments. At KNL_WORDS-1 it wraps to 0 and sets knl_full.
- 1 Image size:
  - o_imgLength←data[LEN_W-1:0]; img_cnt←0; o_KNorIMG←1.
- 2 Image load:
  - o_valid_to_FSM pulse; o_KNorIMG←1.
  - img_cnt (16 bit) increments, wrapping mod 2^16.
- 3 Data request:
  - o_GPIOdata←zero-extended i_MCUdata sampled that edge; o_MCUreq pulse.
- 4 Start:
  - If knl_full=1: go to RUN, o_SoP←1.
  - Otherwise: err←1, stay in IDLE.
- 5 Ack: no-op in IDLE.
- 6 Abort: valid in every state (see below).
- 7 Status: see Configuration.

**Abort (opcode 6), any state.**
- Go to IDLE.
- Clear knl_cnt, knl_full, img_cnt, err, SoP and EOP.
- o_imgLength and o_KNLdata are retained.

**RUN.**
- i_EOP_from_FSM=1 → DONE, o_SoP←0, o_EOP_to_MCU←1.
- Any accepted opcode other than 6 sets err and is otherwise ignored.

**DONE.**
- Opcode 5 → IDLE, o_EOP_to_MCU←0. knl_full is retained, so a restart does not need a kernel reload.
- Opcode 3 is serviced as in IDLE (result readback).
- Other opcodes except 6 set err.

**Simultaneous events.**
- Abort beats i_EOP_from_FSM in the same cycle.
- i_EOP_from_FSM is ignored outside RUN.

## Timing
- **Reset values:**
  - All outputs 0, except o_KNorIMG=1.
  - State IDLE; counters 0.
  - vprev resets to 1, so a strobe held high through reset release is not a command.
- **Latency:** all effects are registered and visible 1 cycle after the accepting edge.
- **Pulses:** o_valid_to_CONV, o_valid_to_FSM and o_MCUreq are high exactly 1 cycle per accepted command.
- **Back-to-back:** minimum strobe period is 2 cycles (one high, one low).
- **Held strobe:** a strobe held high yields one command.
- **Opcode and payload sampling:** i_GPIOctrl and i_GPIOdata are sampled only on the accepting edge; changes at any other time are ignored.
- **Reset mid-RUN:** asynchronous return to reset values; no pulse is emitted.

## Configuration
- Macro: CONV_CTRL_STATUS_EN.
- **Defined:** opcode 7, in any state, loads o_GPIOdata with the status word:
  - [31:30] state
  - [29] err
  - [28] knl_full
  - [27:24] 0
  - [23:16] knl_cnt, zero-extended
  - [15:0] img_cnt
  - Opcode 7 does not set err.
- **Undefined:** opcode 7 is illegal. It sets err and leaves o_GPIOdata unchanged.

## Test plan
- **Reset with strobe held:** reset with i_GPIOvalid held 1, release it, hold 5 cycles → no pulses; o_KNorIMG=1; o_led=0.
- **Kernel load and start:** 3 strobed opcode-0 writes of 0x010203/0x040506/0x070809 → o_KNLaddr 0,1,2 with matching o_KNLdata; three one-cycle o_valid_to_CONV pulses. Then opcode 4 → o_SoP=1 on the next cycle.
- **Start without full kernel:** opcode 4 with only 2 kernel words loaded → stays IDLE; o_led=3'b100. Then opcode 6 → o_led=0.
- **EOP and ack:** in RUN, pulse i_EOP_from_FSM → o_SoP=0, o_EOP_to_MCU=1. Opcode 3 with i_MCUdata=13'h1ABC → o_GPIOdata=0x00001ABC and one o_MCUreq pulse. Opcode 5 → IDLE, EOP=0.
- **Abort vs EOP:** abort strobe and i_EOP_from_FSM in the same RUN cycle → IDLE; o_EOP_to_MCU stays 0.
- **Status readback:** opcode 1 with data 0x000200, then 4 opcode-2 writes, then opcode 7 → o_imgLength=512, four o_valid_to_FSM pulses. With CONV_CTRL_STATUS_EN: o_GPIOdata[15:0]=4, [31:30]=0. Without it: err=1.
